// File: rtl/exe_wb_arbiter.sv
// Execute-to-writeback result arbiter: picks one of MEM/MUL/DIV per cycle
// (MEM > MUL > DIV, with starvation boost for MUL/DIV) into a stallable output register.
module exe_wb_arbiter #(
  parameter int DATA_W       = 64,
  parameter int PREG_W       = 6,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              kill_i,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [PREG_W-1:0] mem_prd_i,
  output logic              mem_ready_o,
  input  logic              mul_valid_i,
  input  logic [DATA_W-1:0] mul_data_i,
  input  logic [PREG_W-1:0] mul_prd_i,
  output logic              mul_ready_o,
  input  logic              div_valid_i,
  input  logic [DATA_W-1:0] div_data_i,
  input  logic [PREG_W-1:0] div_prd_i,
  output logic              div_ready_o,
  input  logic              wb_stall_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [PREG_W-1:0] wb_prd_o,
  output logic [1:0]        wb_src_o,
  output logic              pmu_conflict_o
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MUL  = 2'd2,
    SRC_DIV  = 2'd3
  } src_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  mul_cnt, div_cnt;
  logic              accept, mul_boost, div_boost;
  src_e              grant, src_q;
  logic [DATA_W-1:0] sel_data;
  logic [PREG_W-1:0] sel_prd;
  logic [1:0]        valid_cnt;

  assign accept    = !kill_i && !(wb_valid_o && wb_stall_i);
  assign mul_boost = mul_valid_i && (mul_cnt == LIMIT);
  assign div_boost = div_valid_i && (div_cnt == LIMIT);

  always_comb begin
    grant = SRC_NONE;
    if (accept) begin
      if (mul_boost)        grant = SRC_MUL;
      else if (div_boost)   grant = SRC_DIV;
      else if (mem_valid_i) grant = SRC_MEM;
      else if (mul_valid_i) grant = SRC_MUL;
      else if (div_valid_i) grant = SRC_DIV;
    end
  end

  assign mem_ready_o = (grant == SRC_MEM);
  assign mul_ready_o = (grant == SRC_MUL);
  assign div_ready_o = (grant == SRC_DIV);

  always_comb begin
    sel_data = '0;
    sel_prd  = '0;
    unique case (grant)
      SRC_MEM: begin sel_data = mem_data_i; sel_prd = mem_prd_i; end
      SRC_MUL: begin sel_data = mul_data_i; sel_prd = mul_prd_i; end
      SRC_DIV: begin sel_data = div_data_i; sel_prd = div_prd_i; end
      default: ;
    endcase
  end

  assign valid_cnt = {1'b0, mem_valid_i} + {1'b0, mul_valid_i} + {1'b0, div_valid_i};

  // Counters keep climbing while a stalled output blocks grants.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mul_cnt <= '0;
      div_cnt <= '0;
    end else begin
      if (kill_i || grant == SRC_MUL || !mul_valid_i) mul_cnt <= '0;
      else if (mul_cnt != LIMIT)                     mul_cnt <= mul_cnt + 1'b1;

      if (kill_i || grant == SRC_DIV || !div_valid_i) div_cnt <= '0;
      else if (div_cnt != LIMIT)                     div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_prd_o       <= '0;
      src_q          <= SRC_NONE;
      pmu_conflict_o <= 1'b0;
    end else begin
      pmu_conflict_o <= !kill_i && (valid_cnt >= 2'd2);
      if (kill_i) begin
        wb_valid_o <= 1'b0;
        src_q      <= SRC_NONE;
      end else if (grant != SRC_NONE) begin
        wb_valid_o <= 1'b1;
        wb_data_o  <= sel_data;
        wb_prd_o   <= sel_prd;
        src_q      <= grant;
      end else if (!(wb_stall_i && wb_valid_o)) begin
        wb_valid_o <= 1'b0;
        src_q      <= SRC_NONE;
      end
    end
  end

  assign wb_src_o = src_q;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Bench for exe_wb_arbiter: directed cycle table, async-reset sequence,
// then randomized handshaking sources checked against a reference model.
module tb_exe_wb_arbiter;

  localparam int DATA_W = 64;
  localparam int PREG_W = 6;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rstn_i, kill_i, wb_stall_i;
  logic              mem_valid_i, mul_valid_i, div_valid_i;
  logic [DATA_W-1:0] mem_data_i, mul_data_i, div_data_i;
  logic [PREG_W-1:0] mem_prd_i, mul_prd_i, div_prd_i;
  logic              mem_ready_o, mul_ready_o, div_ready_o;
  logic              wb_valid_o, pmu_conflict_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [PREG_W-1:0] wb_prd_o;
  logic [1:0]        wb_src_o;

  int checks = 0;
  int errors = 0;

  exe_wb_arbiter #(.DATA_W(DATA_W), .PREG_W(PREG_W), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .kill_i(kill_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_prd_i(mem_prd_i), .mem_ready_o(mem_ready_o),
    .mul_valid_i(mul_valid_i), .mul_data_i(mul_data_i), .mul_prd_i(mul_prd_i), .mul_ready_o(mul_ready_o),
    .div_valid_i(div_valid_i), .div_data_i(div_data_i), .div_prd_i(div_prd_i), .div_ready_o(div_ready_o),
    .wb_stall_i(wb_stall_i), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_prd_o(wb_prd_o),
    .wb_src_o(wb_src_o), .pmu_conflict_o(pmu_conflict_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       mv, uv, dv, st, kl;
    logic [2:0] rdy;
    logic       wv;
    logic [1:0] src;
    logic       pmu;
  } vec_t;

  function automatic vec_t mk(logic mv, logic uv, logic dv, logic st, logic kl,
                              logic [2:0] rdy, logic wv, logic [1:0] src, logic pmu);
    vec_t v;
    v.mv = mv; v.uv = uv; v.dv = dv; v.st = st; v.kl = kl;
    v.rdy = rdy; v.wv = wv; v.src = src; v.pmu = pmu;
    return v;
  endfunction

  vec_t tbl[25];

  // Fixed per-source payloads for the directed table: index 1 MEM, 2 MUL, 3 DIV
  logic [DATA_W-1:0] tdata[4];
  logic [PREG_W-1:0] tprd[4];

  // Reference model state (index 0 MEM, 1 MUL, 2 DIV)
  int                m_cnt[3];
  bit                m_ov, m_pmu;
  int                m_src;
  logic [DATA_W-1:0] m_data;
  logic [PREG_W-1:0] m_prd;
  bit                sv[3];
  logic [DATA_W-1:0] sd[3];
  logic [PREG_W-1:0] sp[3];

  task automatic drive_src(input bit v[3], input logic [DATA_W-1:0] d[3], input logic [PREG_W-1:0] p[3]);
    mem_valid_i = v[0]; mem_data_i = d[0]; mem_prd_i = p[0];
    mul_valid_i = v[1]; mul_data_i = d[1]; mul_prd_i = p[1];
    div_valid_i = v[2]; div_data_i = d[2]; div_prd_i = p[2];
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; kill_i = 1'b0; wb_stall_i = 1'b0;
    mem_valid_i = 1'b0; mul_valid_i = 1'b0; div_valid_i = 1'b0;
    mem_data_i = '0; mul_data_i = '0; div_data_i = '0;
    mem_prd_i = '0; mul_prd_i = '0; div_prd_i = '0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;
  endtask

  initial begin
    tdata[0] = '0;         tprd[0] = '0;
    tdata[1] = 64'hA5;     tprd[1] = 6'd7;
    tdata[2] = 64'h1111;   tprd[2] = 6'd2;
    tdata[3] = 64'h2222;   tprd[3] = 6'd3;

    //            mv uv dv st kl  rdy     wv src pmu
    tbl[0]  = mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 3'b000, 1, 1, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 3'b100, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 3'b010, 1, 1, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 3'b001, 1, 2, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 3'b000, 1, 3, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 3'b100, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 3'b100, 1, 1, 1);
    tbl[8]  = mk(1, 1, 0, 0, 0, 3'b100, 1, 1, 1);
    tbl[9]  = mk(1, 1, 0, 0, 0, 3'b100, 1, 1, 1);
    tbl[10] = mk(1, 1, 0, 0, 0, 3'b010, 1, 1, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 3'b100, 1, 2, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 3'b000, 1, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 1, 0, 3'b000, 1, 1, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 3'b000, 1, 1, 0);
    tbl[16] = mk(0, 0, 1, 1, 0, 3'b000, 1, 1, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 3'b001, 1, 1, 0);
    tbl[18] = mk(0, 1, 0, 0, 1, 3'b000, 1, 3, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 3'b010, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 3'b000, 1, 2, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 3'b100, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 1, 0, 3'b000, 1, 1, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 3'b000, 1, 1, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);

    do_reset();
    chk("reset_wb_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("reset_wb_src", {62'd0, wb_src_o}, 64'd0);
    chk("reset_pmu", {63'd0, pmu_conflict_o}, 64'd0);

    // Directed table: inputs applied just after posedge, checked at negedge
    for (int i = 0; i < 25; i++) begin
      mem_valid_i = tbl[i].mv; mem_data_i = tdata[1]; mem_prd_i = tprd[1];
      mul_valid_i = tbl[i].uv; mul_data_i = tdata[2]; mul_prd_i = tprd[2];
      div_valid_i = tbl[i].dv; div_data_i = tdata[3]; div_prd_i = tprd[3];
      wb_stall_i  = tbl[i].st; kill_i = tbl[i].kl;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), {61'd0, mem_ready_o, mul_ready_o, div_ready_o}, {61'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_wb_valid", i), {63'd0, wb_valid_o}, {63'd0, tbl[i].wv});
      chk($sformatf("tbl%0d_wb_src", i), {62'd0, wb_src_o}, {62'd0, tbl[i].src});
      chk($sformatf("tbl%0d_pmu", i), {63'd0, pmu_conflict_o}, {63'd0, tbl[i].pmu});
      if (tbl[i].wv) begin
        chk($sformatf("tbl%0d_wb_data", i), wb_data_o, tdata[tbl[i].src]);
        chk($sformatf("tbl%0d_wb_prd", i), {58'd0, wb_prd_o}, {58'd0, tprd[tbl[i].src]});
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset while the output is valid and stalled
    mem_valid_i = 1'b1; mem_data_i = 64'hA5; mem_prd_i = 6'd7;
    mul_valid_i = 1'b0; div_valid_i = 1'b0; wb_stall_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    chk("rst_seq_mem_ready", {63'd0, mem_ready_o}, 64'd1);
    @(posedge clk); #1;
    mem_valid_i = 1'b0; wb_stall_i = 1'b1;
    @(negedge clk);
    chk("rst_seq_valid_before", {63'd0, wb_valid_o}, 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_async_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("rst_async_data", wb_data_o, 64'd0);
    chk("rst_async_prd", {58'd0, wb_prd_o}, 64'd0);
    chk("rst_async_src", {62'd0, wb_src_o}, 64'd0);
    @(posedge clk); #1;
    rstn_i = 1'b1; wb_stall_i = 1'b0;
    mem_valid_i = 1'b1; mem_data_i = 64'h5A; mem_prd_i = 6'd9;
    @(negedge clk);
    chk("post_rst_mem_ready", {63'd0, mem_ready_o}, 64'd1);
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_wb_valid", {63'd0, wb_valid_o}, 64'd1);
    chk("post_rst_wb_data", wb_data_o, 64'h5A);
    chk("post_rst_wb_prd", {58'd0, wb_prd_o}, 64'd9);
    chk("post_rst_wb_src", {62'd0, wb_src_o}, 64'd1);

    // Randomized phase against the reference model
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; sv[i] = 1'b0; sd[i] = '0; sp[i] = '0;
    end
    m_ov = 1'b0; m_pmu = 1'b0; m_src = 0; m_data = '0; m_prd = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      bit accept, st, kl;
      int g, nvalid;
      st = ($urandom_range(0, 2) == 0);
      kl = ($urandom_range(0, 15) == 0);
      drive_src(sv, sd, sp);
      wb_stall_i = st; kill_i = kl;
      @(negedge clk);

      // Grant choice straight from the priority rules
      accept = !kl && !(m_ov && st);
      g = -1;
      if (accept) begin
        if (sv[1] && m_cnt[1] == LIMIT)      g = 1;
        else if (sv[2] && m_cnt[2] == LIMIT) g = 2;
        else begin
          for (int s = 0; s < 3; s++)
            if (g < 0 && sv[s]) g = s;
        end
      end

      chk("rnd_mem_ready", {63'd0, mem_ready_o}, {63'd0, g == 0});
      chk("rnd_mul_ready", {63'd0, mul_ready_o}, {63'd0, g == 1});
      chk("rnd_div_ready", {63'd0, div_ready_o}, {63'd0, g == 2});
      chk("rnd_wb_valid", {63'd0, wb_valid_o}, {63'd0, m_ov});
      chk("rnd_wb_src", {62'd0, wb_src_o}, 64'(m_src));
      chk("rnd_pmu", {63'd0, pmu_conflict_o}, {63'd0, m_pmu});
      if (m_ov) begin
        chk("rnd_wb_data", wb_data_o, m_data);
        chk("rnd_wb_prd", {58'd0, wb_prd_o}, {58'd0, m_prd});
      end

      @(posedge clk); #1;

      for (int s = 1; s < 3; s++) begin
        if (kl || g == s || !sv[s]) m_cnt[s] = 0;
        else if (m_cnt[s] < LIMIT)  m_cnt[s] = m_cnt[s] + 1;
      end
      nvalid = int'(sv[0]) + int'(sv[1]) + int'(sv[2]);
      m_pmu = !kl && (nvalid >= 2);
      if (kl) begin
        m_ov = 1'b0; m_src = 0;
      end else if (g >= 0) begin
        m_ov = 1'b1; m_src = g + 1; m_data = sd[g]; m_prd = sp[g];
      end else if (!(st && m_ov)) begin
        m_ov = 1'b0; m_src = 0;
      end

      // Sources hold until granted, then maybe present a fresh result
      for (int s = 0; s < 3; s++) begin
        if (g == s || !sv[s]) begin
          sv[s] = (s == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
          sd[s] = {$urandom, $urandom};
          sp[s] = PREG_W'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
